// File: rtl/decoder_pkg.sv
// Shared types and helpers for the scanning one-hot decoder.
package decoder_pkg;

  localparam int DEFAULT_IN_W    = 3;
  localparam int DEFAULT_DWELL_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2,
    BLANK  = 2'd3
  } state_t;

  // One-hot of index within a 64-line field; lines at or above width stay zero.
  function automatic logic [63:0] onehot_of(input logic [5:0] index, input int width);
    logic [63:0] v;
    v = '0;
    if (int'(index) < width) v[index] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder_scan_seq_dwell_counter.sv
// Dwell counter: counts 0..max, restarting on clear or after the terminal count.
module dwell_counter
  import decoder_pkg::*;
#(
  parameter int DWELL_W = DEFAULT_DWELL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               enable,
  input  logic [DWELL_W-1:0] max,
  output logic [DWELL_W-1:0] count,
  output logic               terminal
);

  // >= so that lowering max mid-dwell still ends the dwell promptly.
  assign terminal = (count >= max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || (enable && terminal)) begin
      count <= '0;
    end else if (enable) begin
      count <= count + {{(DWELL_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/decoder_scan_seq.sv
// Registered binary-to-one-hot decoder with direct and dwell-timed scan modes.
// Optional DECODER_SCAN_BLANK_EN inserts one blank cycle before each scan step's new line.
module decoder_scan_seq
  import decoder_pkg::*;
#(
  parameter  int IN_W    = DEFAULT_IN_W,
  parameter  int DWELL_W = DEFAULT_DWELL_W,
  localparam int OUT_W   = 1 << IN_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               En,
  input  logic               Mode,
  input  logic [IN_W-1:0]    In,
  input  logic               Load,
  input  logic [DWELL_W-1:0] DwellMax,
  output logic [OUT_W-1:0]   Out,
  output logic [IN_W-1:0]    Index,
  output logic               Wrap
);

  state_t            state_reg, state_next;
  logic [IN_W-1:0]   index_reg, index_next;
  logic [OUT_W-1:0]  out_reg, out_next;
  logic              wrap_reg, wrap_next;
  logic              cnt_clear, cnt_enable;
  logic [DWELL_W-1:0] dwell_count;
  logic              terminal;
  logic [63:0]       onehot_full;
  logic              unused_count;

  dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
    .clk      (Clk),
    .rst      (Reset),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .max      (DwellMax),
    .count    (dwell_count),
    .terminal (terminal)
  );

  // Only the terminal flag steers the sequencer; the raw count is informational.
  assign unused_count = ^dwell_count;

  always_comb begin
    state_next = IDLE;
    index_next = index_reg;
    wrap_next  = 1'b0;
    cnt_clear  = 1'b1;
    cnt_enable = 1'b0;
    if (En && !Mode) begin
      state_next = DIRECT;
      index_next = In;
    end else if (En && Mode) begin
      state_next = SCAN;
      if (Load) begin
        index_next = In;
      end else if (state_reg == SCAN) begin
        cnt_clear  = 1'b0;
        cnt_enable = 1'b1;
        if (terminal) begin
          index_next = index_reg + IN_W'(1);
          wrap_next  = (index_reg == {IN_W{1'b1}});
`ifdef DECODER_SCAN_BLANK_EN
          state_next = BLANK;
`endif
        end
      end
    end
  end

  assign onehot_full = onehot_of(6'(index_next), OUT_W);

  always_comb begin
    out_next = '0;
    if (state_next == DIRECT || state_next == SCAN) out_next = onehot_full[OUT_W-1:0];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
      index_reg <= '0;
      out_reg   <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
      out_reg   <= out_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign Out   = out_reg;
  assign Index = index_reg;
  assign Wrap  = wrap_reg;

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Scoreboard bench for decoder_scan_seq: driver queues expected outputs, monitor checks each cycle.
module tb_decoder_scan_seq;

`ifdef DECODER_SCAN_BLANK_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  typedef struct {
    logic [7:0] out;
    logic [2:0] idx;
    logic       wrap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] in_sel = 3'd0;
  logic       load = 1'b0;
  logic [7:0] dwell_max = 8'd0;
  logic [7:0] out;
  logic [2:0] idx;
  logic       wrap;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  decoder_scan_seq #(.IN_W(3), .DWELL_W(8)) dut (
    .Clk      (clk),
    .Reset    (rst),
    .En       (en),
    .Mode     (mode),
    .In       (in_sel),
    .Load     (load),
    .DwellMax (dwell_max),
    .Out      (out),
    .Index    (idx),
    .Wrap     (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] oh(input int i);
    logic [7:0] one;
    one = 8'd1;
    return one << i;
  endfunction

  task automatic check_now(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle checks one-hot-ness, and pops/compares any queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    check_now("onehot0", {7'd0, $onehot0(out)}, 8'd1);
    if (q.size() > 0) begin
      e = q.pop_front();
      check_now("out", out, e.out);
      check_now("index", {5'd0, idx}, {5'd0, e.idx});
      check_now("wrap", {7'd0, wrap}, {7'd0, e.wrap});
      $display("t=%0t out=%h index=%0d wrap=%0b (exp %h/%0d/%0b)",
               $time, out, idx, wrap, e.out, e.idx, e.wrap);
    end
  end

  task automatic set_in(input logic e, input logic m, input int i, input logic l, input int d);
    en = e; mode = m; in_sel = 3'(i); load = l; dwell_max = 8'(d);
  endtask

  // Queue the expectation for the cycle after the next edge, then advance to the following negedge.
  task automatic cyc(input logic [7:0] o, input int i, input logic w);
    exp_t e;
    e.out = o; e.idx = 3'(i); e.wrap = w;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic enter_line(input int i);
    if (GAP != 0) begin
      cyc(8'h00, i, i == 0);
      cyc(oh(i), i, 1'b0);
    end else begin
      cyc(oh(i), i, i == 0);
    end
  endtask

  // Assumes the last queued cycle is the first (count 0) cycle of line `start`.
  task automatic expect_scan(input int start, input int steps, input int dm);
    int i;
    i = start;
    for (int s = 0; s < steps; s++) begin
      for (int d = 0; d < dm; d++) cyc(oh(i), i, 1'b0);
      i = (i + 1) % 8;
      enter_line(i);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check_now("reset_out", out, 8'h00);
    check_now("reset_index", {5'd0, idx}, 8'h00);
    check_now("reset_wrap", {7'd0, wrap}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Direct decode
    set_in(1, 0, 5, 0, 0); cyc(8'h20, 5, 0);
    set_in(1, 0, 0, 0, 0); cyc(8'h01, 0, 0);
    set_in(1, 0, 7, 0, 0); cyc(8'h80, 7, 0);
    set_in(1, 0, 2, 1, 9); cyc(8'h04, 2, 0);

    // Enter scan retaining Index, then load 6 with 3-cycle dwell
    set_in(1, 1, 0, 0, 2); cyc(8'h04, 2, 0);
    set_in(1, 1, 6, 1, 2); cyc(8'h40, 6, 0);
    set_in(1, 1, 6, 0, 2); expect_scan(6, 3, 2);

    // Step every cycle, wrapping twice
    set_in(1, 1, 0, 1, 0); cyc(8'h01, 0, 0);
    set_in(1, 1, 0, 0, 0); expect_scan(0, 17, 0);

    // Load coinciding with terminal count
    set_in(1, 1, 5, 1, 2); cyc(8'h20, 5, 0);
    set_in(1, 1, 5, 0, 2); cyc(8'h20, 5, 0); cyc(8'h20, 5, 0);
    set_in(1, 1, 3, 1, 2); cyc(8'h08, 3, 0);
    set_in(1, 1, 3, 0, 2); expect_scan(3, 1, 2);

    // Drop En at Index 4, then resume with a full dwell
    set_in(0, 1, 0, 0, 2); cyc(8'h00, 4, 0);
    set_in(1, 1, 0, 0, 2); cyc(8'h10, 4, 0);
    expect_scan(4, 1, 2);

    // DwellMax=1 line pattern
    set_in(1, 1, 7, 1, 1); cyc(8'h80, 7, 0);
    set_in(1, 1, 7, 0, 1);
`ifdef DECODER_SCAN_BLANK_EN
    cyc(8'h80, 7, 0); cyc(8'h00, 0, 1); cyc(8'h01, 0, 0); cyc(8'h01, 0, 0); cyc(8'h00, 1, 0);
    set_in(1, 1, 5, 1, 1); cyc(8'h20, 5, 0);
    set_in(1, 1, 5, 0, 1); cyc(8'h20, 5, 0); cyc(8'h00, 6, 0); cyc(8'h40, 6, 0);
`else
    cyc(8'h80, 7, 0); cyc(8'h01, 0, 1); cyc(8'h01, 0, 0); cyc(8'h02, 1, 0);
`endif

    // DwellMax lowered below the running count steps on the next edge
    set_in(1, 1, 2, 1, 5); cyc(8'h04, 2, 0);
    set_in(1, 1, 2, 0, 5); cyc(8'h04, 2, 0); cyc(8'h04, 2, 0);
    set_in(1, 1, 2, 0, 1); enter_line(3);
    set_in(1, 1, 2, 0, 3); cyc(8'h08, 3, 0);

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    check_now("async_rst_out", out, 8'h00);
    check_now("async_rst_index", {5'd0, idx}, 8'h00);
    check_now("async_rst_wrap", {7'd0, wrap}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    set_in(1, 1, 0, 0, 3); cyc(8'h01, 0, 0);
    set_in(1, 0, 1, 0, 3); cyc(8'h02, 1, 0);
    set_in(0, 0, 1, 0, 3); cyc(8'h00, 1, 0);

    check_now("queue_drained", 8'(q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decoder_scan_seq.md
Name: decoder_scan_seq

Overview:
- Parametrised registered binary-to-one-hot decoder, IN_W to 2^IN_W.
- Two modes:
  - Direct mode: registers the decode of In.
  - Scan mode: rotates the one-hot output through all lines, with a programmable dwell time per line.
- Used as a write-select decoder for register files/memories and as the digit/row scanner for multiplexed display and keypad logic.

Parameters:
- IN_W, 3, select width; OUT_W is a derived localparam equal to 1 << IN_W; legal range 1..6.
- DWELL_W, 8, width of the dwell-time field and the dwell counter.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- En  input  1  block enable; 0 forces blank output.
- Mode  input  1  0 = direct decode, 1 = scan.
- In  input  IN_W  binary select (direct) or scan start index (on Load).
- Load  input  1  scan mode only: load Index from In and restart dwell.
- DwellMax  input  DWELL_W  a line stays active for DwellMax+1 cycles in scan mode.
- Out  output  OUT_W  registered one-hot output, or all zero.
- Index  output  IN_W  registered binary index of the active line.
- Wrap  output  1  one-cycle pulse when the scan index wraps from OUT_W-1 to 0.

Behaviour:
- Clock and reset: one clock Clk; Reset asynchronous, active-high. While Reset is high:
  - Out=0, Index=0, Wrap=0.
  - Dwell counter=0, state=IDLE.
- States: IDLE, DIRECT, SCAN. State is selected each cycle from En/Mode:
  - En=0 -> IDLE.
  - En=1 & Mode=0 -> DIRECT.
  - En=1 & Mode=1 -> SCAN.
- All outputs are registered; every input change is visible at Out one cycle later.
- IDLE:
  - Out=0, Wrap=0, dwell counter cleared, Index holds its last value.
- DIRECT:
  - Out <= 1 << In; Index <= In; latency 1 cycle.
  - Load, DwellMax ignored; Wrap=0.
- SCAN:
  - Out always equals 1 << Index of the same cycle.
  - Dwell counter counts 0..DwellMax. At DwellMax: counter <= 0 and Index <= Index+1 modulo OUT_W.
  - Wrap=1 for exactly the cycle in which the new Index=0 appears after stepping from OUT_W-1.
  - Load=1: Index <= In, counter <= 0, no step and no Wrap that cycle. Load has priority over a step in the same cycle.
  - Entering SCAN from IDLE or DIRECT:
    - Index is retained unless Load=1; counter starts at 0.
    - First active line is 1 << Index on the first SCAN cycle.
  - DwellMax=0: step every cycle.
  - DwellMax changed mid-dwell: the new value applies on the next comparison. If the counter is already >= the new DwellMax, step on the next cycle (compare with >=).
- Mode/En change mid-scan: takes effect the next cycle; counter cleared; Wrap never asserted outside SCAN.
- Out is never multi-hot in any state or transition.
- Reset asserted mid-operation: outputs clear immediately (asynchronous). The first post-reset cycle follows the state rules above.

Optional Feature:
- Macro: DECODER_SCAN_BLANK_EN.
- Defined:
  - Adds state BLANK. Every scan step (including Wrap steps, excluding Load) inserts exactly one cycle with Out=0 before the new line drives.
  - Index updates on entry to BLANK; Wrap pulses in the BLANK cycle.
  - A Load during BLANK reloads Index and ends BLANK.
  - Per-line period = DwellMax+2 cycles.
- Undefined: no BLANK state; per-line period = DwellMax+1 cycles; no gap cycles.

Decomposition:
- Package decoder_pkg:
  - state enum (IDLE, DIRECT, SCAN, BLANK);
  - constant function onehot_of(index, width);
  - default IN_W/DWELL_W constants.
- One natural sub-module: dwell_counter. Inputs: clear, enable, max. Outputs: count, terminal flag (count >= max). It holds the DWELL_W counter and comparison.
- Top-level holds the state register, Index register and output decode.

Test Plan:
- Reset then En=1, Mode=0, In=5 -> next cycle Out=8'b0010_0000, Index=5; In=0 -> Out=8'b0000_0001 one cycle later.
- Mode=1, Load=1, In=6, then Load=0, DwellMax=2 -> lines held 3 cycles each:
  - Out=0x40, then 0x80.
  - Then 0x01 with Wrap=1 for one cycle.
  - Then 0x02.
- Scan with DwellMax=0 -> Index increments every cycle; Wrap every 8th cycle; Out one-hot at every cycle boundary (checked by assertion).
- Load=1 coinciding with a terminal count, In=3 -> Index=3, no step, no Wrap; dwell restarts from 0.
- En dropped mid-scan at Index=4 -> Out=0 next cycle, Index stays 4; En restored with Mode=1 -> Out=0x10 with a full dwell.
- Reset asserted asynchronously mid-dwell, between clock edges -> Out=0, Index=0, Wrap=0 before the next edge.
- With DECODER_SCAN_BLANK_EN, DwellMax=1 -> pattern per line is active, active, zero; Wrap lands on the zero cycle preceding 0x01.
